rgb_hue_cycler: RTL and testbench

Parametrised N-channel hue-wheel PWM generator, successor to the fixed three-channel RGB colour cycler in `top`. It sweeps a continuous hue wheel of `2*CHANNELS` segments and drives one glitch-free PWM output per channel. It sits between the board clock and the LED pins, with `pwm_out[0..2]` mapping to `RGB_R`, `RGB_G` and `RGB_B` on the iCE40 board. It adds run/freeze control, a position readout and an optional reverse sweep.

---
 rtl/hue_cycler_pkg.sv | 31 +++
 rtl/rgb_hue_cycler_pwm_channel.sv | 65 ++++++
 rtl/rgb_hue_cycler.sv | 144 ++++++++++++++
 tb/tb_rgb_hue_cycler.sv | 247 ++++++++++++++++++++++++
 4 files changed

// File: rtl/hue_cycler_pkg.sv
// ============================================================================
// hue_cycler_pkg: segment kinds and the per-channel segment decode.
// Revision: 1.0
// ============================================================================
`default_nettype none

package hue_cycler_pkg;

  typedef enum logic [1:0] {
    HIGH = 2'd0,
    FALL = 2'd1,
    LOW  = 2'd2,
    RISE = 2'd3
  } seg_kind_t;

  // Channel k sees the wheel rotated back by 2k segments; k < nseg/2 keeps the sum positive.
  function automatic seg_kind_t seg_kind(input int unsigned seg,
                                         input int unsigned k,
                                         input int unsigned nseg);
    int unsigned s;
    s = seg + nseg - 2 * k;
    if (s >= nseg) s = s - nseg;
    if (s == 0 || s == nseg - 1) return HIGH;
    else if (s == 1)             return FALL;
    else if (s == nseg - 2)      return RISE;
    else                         return LOW;
  endfunction

endpackage

`default_nettype wire

// File: rtl/rgb_hue_cycler_pwm_channel.sv
// ============================================================================
// pwm_channel: segment decode, duty register and PWM compare for one output.
// Revision: 1.0
// ============================================================================
`default_nettype none

module pwm_channel
  import hue_cycler_pkg::*;
#(
  parameter int CHANNELS     = 3,
  parameter int PWM_INTERVAL = 1200,
  parameter int HUE_STEPS    = 100,
  parameter int CH_IDX       = 0,
  parameter int CNT_W        = 11,
  parameter int SEG_W        = 3,
  parameter int IDX_W        = 7
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             enable,
  input  logic             load,
  input  logic [CNT_W-1:0] pwm_cnt,
  input  logic [SEG_W-1:0] hue_seg,
  input  logic [IDX_W-1:0] hue_idx,
  output logic             pwm_out
);

  localparam int DUTY_STEP = PWM_INTERVAL / HUE_STEPS;
  localparam int NSEG      = 2 * CHANNELS;
  localparam int DUTY_W    = $clog2(PWM_INTERVAL + 1);

  logic [DUTY_W-1:0] duty_q, duty_d;
  logic [DUTY_W-1:0] ramp;
  logic [DUTY_W-1:0] duty_new;
  logic              pwm_out_q, pwm_out_d;

  always_comb begin
    ramp     = DUTY_W'(32'(hue_idx) * DUTY_STEP);
    duty_new = '0;
    case (seg_kind(32'(hue_seg), 32'(CH_IDX), 32'(NSEG)))
      HIGH:    duty_new = DUTY_W'(PWM_INTERVAL);
      FALL:    duty_new = DUTY_W'(PWM_INTERVAL) - ramp;
      RISE:    duty_new = ramp;
      default: duty_new = '0;
    endcase
    // Duty changes only on a period boundary so a period is never cut short.
    duty_d    = load ? duty_new : duty_q;
    pwm_out_d = enable && (DUTY_W'(pwm_cnt) < duty_q);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      duty_q    <= '0;
      pwm_out_q <= 1'b0;
    end else begin
      duty_q    <= duty_d;
      pwm_out_q <= pwm_out_d;
    end
  end

  assign pwm_out = pwm_out_q;

endmodule

`default_nettype wire

// File: rtl/rgb_hue_cycler.sv
// ============================================================================
// rgb_hue_cycler: N-channel hue-wheel PWM generator with run/freeze control.
// Optional reverse sweep and dir port: define HUE_CYCLER_REVERSE_EN. Rev 1.0
// ============================================================================
`default_nettype none

module rgb_hue_cycler
  import hue_cycler_pkg::*;
#(
  parameter int CHANNELS     = 3,
  parameter int PWM_INTERVAL = 1200,
  parameter int HUE_STEPS    = 100,
  parameter int STEP_PERIODS = 16
) (
`ifdef HUE_CYCLER_REVERSE_EN
  input  logic                            dir,
`endif
  input  logic                            clk,
  input  logic                            rst_n,
  input  logic                            enable,
  input  logic                            freeze,
  output logic [CHANNELS-1:0]             pwm_out,
  output logic [$clog2(2*CHANNELS)-1:0]   hue_seg,
  output logic [$clog2(HUE_STEPS)-1:0]    hue_idx,
  output logic                            wheel_wrap
);

  localparam int NSEG   = 2 * CHANNELS;
  localparam int SEG_W  = $clog2(NSEG);
  localparam int IDX_W  = $clog2(HUE_STEPS);
  localparam int CNT_W  = (PWM_INTERVAL > 1) ? $clog2(PWM_INTERVAL) : 1;
  localparam int STEP_W = (STEP_PERIODS > 1) ? $clog2(STEP_PERIODS) : 1;

  localparam logic [CNT_W-1:0]  CNT_LAST  = CNT_W'(PWM_INTERVAL - 1);
  localparam logic [STEP_W-1:0] STEP_LAST = STEP_W'(STEP_PERIODS - 1);
  localparam logic [SEG_W-1:0]  SEG_LAST  = SEG_W'(NSEG - 1);
  localparam logic [IDX_W-1:0]  IDX_LAST  = IDX_W'(HUE_STEPS - 1);

  logic [CNT_W-1:0]  pwm_cnt_q, pwm_cnt_d;
  logic [STEP_W-1:0] step_cnt_q, step_cnt_d;
  logic [SEG_W-1:0]  hue_seg_q, hue_seg_d;
  logic [IDX_W-1:0]  hue_idx_q, hue_idx_d;
  logic              wheel_wrap_q, wheel_wrap_d;
  logic              period_end;
  logic              reverse;

`ifdef HUE_CYCLER_REVERSE_EN
  assign reverse = dir;
`else
  assign reverse = 1'b0;
`endif

  assign period_end = enable && (pwm_cnt_q == CNT_LAST);

  always_comb begin
    pwm_cnt_d    = pwm_cnt_q + 1'b1;
    step_cnt_d   = step_cnt_q;
    hue_seg_d    = hue_seg_q;
    hue_idx_d    = hue_idx_q;
    wheel_wrap_d = 1'b0;

    if (!enable || period_end) pwm_cnt_d = '0;

    if (period_end && !freeze) begin
      if (step_cnt_q != STEP_LAST) begin
        step_cnt_d = step_cnt_q + 1'b1;
      end else begin
        step_cnt_d = '0;
        if (!reverse) begin
          if (hue_idx_q == IDX_LAST) begin
            hue_idx_d = '0;
            if (hue_seg_q == SEG_LAST) begin
              hue_seg_d    = '0;
              wheel_wrap_d = 1'b1;
            end else begin
              hue_seg_d = hue_seg_q + 1'b1;
            end
          end else begin
            hue_idx_d = hue_idx_q + 1'b1;
          end
        end else begin
          if (hue_idx_q == '0) begin
            hue_idx_d = IDX_LAST;
            if (hue_seg_q == '0) begin
              hue_seg_d    = SEG_LAST;
              wheel_wrap_d = 1'b1;
            end else begin
              hue_seg_d = hue_seg_q - 1'b1;
            end
          end else begin
            hue_idx_d = hue_idx_q - 1'b1;
          end
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pwm_cnt_q    <= '0;
      step_cnt_q   <= '0;
      hue_seg_q    <= '0;
      hue_idx_q    <= '0;
      wheel_wrap_q <= 1'b0;
    end else begin
      pwm_cnt_q    <= pwm_cnt_d;
      step_cnt_q   <= step_cnt_d;
      hue_seg_q    <= hue_seg_d;
      hue_idx_q    <= hue_idx_d;
      wheel_wrap_q <= wheel_wrap_d;
    end
  end

  // Channels load from the pre-edge hue position, so duties trail it by one period.
  generate
    for (genvar k = 0; k < CHANNELS; k++) begin : g_channel
      pwm_channel #(
        .CHANNELS     (CHANNELS),
        .PWM_INTERVAL (PWM_INTERVAL),
        .HUE_STEPS    (HUE_STEPS),
        .CH_IDX       (k),
        .CNT_W        (CNT_W),
        .SEG_W        (SEG_W),
        .IDX_W        (IDX_W)
      ) u_channel (
        .clk     (clk),
        .rst_n   (rst_n),
        .enable  (enable),
        .load    (period_end),
        .pwm_cnt (pwm_cnt_q),
        .hue_seg (hue_seg_q),
        .hue_idx (hue_idx_q),
        .pwm_out (pwm_out[k])
      );
    end
  endgenerate

  assign hue_seg    = hue_seg_q;
  assign hue_idx    = hue_idx_q;
  assign wheel_wrap = wheel_wrap_q;

endmodule

`default_nettype wire

// File: tb/tb_rgb_hue_cycler.sv
// ============================================================================
// tb_rgb_hue_cycler: directed scenarios plus randomized control against a
// position-based hue-wheel model. Revision: 1.0
// ============================================================================
`default_nettype none

module tb_rgb_hue_cycler;

  localparam int CH   = 3;
  localparam int PI   = 12;
  localparam int HS   = 4;
  localparam int SP   = 2;
  localparam int NSEG = 2 * CH;
  localparam int NPOS = NSEG * HS;
  localparam int DS   = PI / HS;

  logic          clk = 1'b0;
  logic          rst_n = 1'b1;
  logic          enable = 1'b0;
  logic          freeze = 1'b0;
  logic          dir = 1'b0;
  logic [CH-1:0] pwm_out;
  logic [2:0]    hue_seg;
  logic [1:0]    hue_idx;
  logic          wheel_wrap;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  rgb_hue_cycler #(
    .CHANNELS     (CH),
    .PWM_INTERVAL (PI),
    .HUE_STEPS    (HS),
    .STEP_PERIODS (SP)
  ) dut (
`ifdef HUE_CYCLER_REVERSE_EN
    .dir        (dir),
`endif
    .clk        (clk),
    .rst_n      (rst_n),
    .enable     (enable),
    .freeze     (freeze),
    .pwm_out    (pwm_out),
    .hue_seg    (hue_seg),
    .hue_idx    (hue_idx),
    .wheel_wrap (wheel_wrap)
  );

  // ---------------- reference model: one integer wheel position ------------
  int            m_cnt = 0;
  int            m_step = 0;
  int            m_pos = 0;
  int            m_duty [CH];
  logic [CH-1:0] m_out = '0;
  logic          m_wrap = 1'b0;
  logic          m_rev;

`ifdef HUE_CYCLER_REVERSE_EN
  assign m_rev = dir;
`else
  assign m_rev = 1'b0;
`endif

  function automatic int duty_of(input int pos, input int k);
    int r, s, i;
    r = (pos - 2 * k * HS + NPOS) % NPOS;
    s = r / HS;
    i = r % HS;
    if (s == 0 || s == NSEG - 1) return PI;
    if (s == 1)                  return PI - i * DS;
    if (s == NSEG - 2)           return i * DS;
    return 0;
  endfunction

  initial for (int k = 0; k < CH; k++) m_duty[k] = 0;

  always @(posedge clk or negedge rst_n) begin
    bit pe;
    if (!rst_n) begin
      m_cnt  = 0;
      m_step = 0;
      m_pos  = 0;
      m_out  = '0;
      m_wrap = 1'b0;
      for (int k = 0; k < CH; k++) m_duty[k] = 0;
    end else begin
      pe = enable && (m_cnt == PI - 1);
      for (int k = 0; k < CH; k++) m_out[k] = enable && (m_cnt < m_duty[k]);
      m_wrap = 1'b0;
      if (pe) begin
        for (int k = 0; k < CH; k++) m_duty[k] = duty_of(m_pos, k);
        if (!freeze) begin
          if (m_step == SP - 1) begin
            m_step = 0;
            if (m_rev) begin
              m_wrap = (m_pos == 0);
              m_pos  = (m_pos + NPOS - 1) % NPOS;
            end else begin
              m_wrap = (m_pos == NPOS - 1);
              m_pos  = (m_pos + 1) % NPOS;
            end
          end else begin
            m_step = m_step + 1;
          end
        end
      end
      m_cnt = (!enable || pe) ? 0 : m_cnt + 1;
    end
  end

  always @(negedge clk) begin
    n_checks++;
    if ({pwm_out, hue_seg, hue_idx, wheel_wrap} !==
        {m_out, 3'(m_pos / HS), 2'(m_pos % HS), m_wrap}) begin
      n_errors++;
      $display("FAIL cycle t=%0t got pwm_out=%b seg=%0d idx=%0d wrap=%b want pwm_out=%b seg=%0d idx=%0d wrap=%b",
               $time, pwm_out, hue_seg, hue_idx, wheel_wrap,
               m_out, m_pos / HS, m_pos % HS, m_wrap);
    end
  end

  // ---------------- directed helpers ----------------------------------------
  int hi_cnt [CH];
  int wrap_cnt = 0;

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s got %0d want %0d", name, act, exp);
    end
  endtask

  task automatic run_period();
    for (int k = 0; k < CH; k++) hi_cnt[k] = 0;
    repeat (PI) begin
      @(posedge clk);
      @(negedge clk);
      for (int k = 0; k < CH; k++) if (pwm_out[k]) hi_cnt[k]++;
      if (wheel_wrap) wrap_cnt++;
    end
  endtask

  initial begin
    bit found;
    #1 rst_n = 1'b0;
    repeat (3) @(negedge clk);
    check("reset_pwm_out", int'(pwm_out), 0);
    check("reset_hue_seg", int'(hue_seg), 0);
    check("reset_hue_idx", int'(hue_idx), 0);
    check("reset_wrap", int'(wheel_wrap), 0);

    rst_n  = 1'b1;
    enable = 1'b1;
    run_period();
    check("p1_out0", hi_cnt[0], 0);
    check("p1_out1", hi_cnt[1], 0);
    check("p1_out2", hi_cnt[2], 0);
    run_period();
    check("p2_out0", hi_cnt[0], 12);
    check("p2_out1", hi_cnt[1], 0);
    check("p2_out2", hi_cnt[2], 0);
    check("p2_hue_idx", int'(hue_idx), 1);
    run_period();
    run_period();
    check("p4_out1_ramp", hi_cnt[1], 3);
    check("p4_out0", hi_cnt[0], 12);

    repeat (44) run_period();
    check("wrap_hue_seg", int'(hue_seg), 0);
    check("wrap_hue_idx", int'(hue_idx), 0);
    check("wrap_pulses", wrap_cnt, 1);

    repeat (4) run_period();
    check("pre_freeze_idx", int'(hue_idx), 2);
    freeze = 1'b1;
    repeat (10) run_period();
    check("freeze_seg", int'(hue_seg), 0);
    check("freeze_idx", int'(hue_idx), 2);
    check("freeze_out0", hi_cnt[0], 12);
    check("freeze_out1", hi_cnt[1], 6);
    check("freeze_out2", hi_cnt[2], 0);

    repeat (5) begin @(posedge clk); @(negedge clk); end
    enable = 1'b0;
    @(posedge clk); @(negedge clk);
    check("disable_out", int'(pwm_out), 0);
    repeat (3) begin @(posedge clk); @(negedge clk); end
    enable = 1'b1;
    run_period();
    check("reenable_out0", hi_cnt[0], 12);
    check("reenable_out1", hi_cnt[1], 6);
    check("reenable_idx", int'(hue_idx), 2);

    freeze = 1'b0;
    found  = 1'b0;
    for (int p = 0; p < 100 && !found; p++) begin
      run_period();
      if (hue_seg == 3'd3 && hue_idx == 2'd2) found = 1'b1;
    end
    check("reach_3_2", int'(found), 1);
    repeat (4) begin @(posedge clk); @(negedge clk); end
    check("pre_reset_out2", int'(pwm_out[2]), 1);
    #2 rst_n = 1'b0;
    #1;
    check("areset_out", int'(pwm_out), 0);
    check("areset_seg", int'(hue_seg), 0);
    check("areset_idx", int'(hue_idx), 0);

`ifdef HUE_CYCLER_REVERSE_EN
    dir = 1'b1;
    @(negedge clk);
    rst_n    = 1'b1;
    wrap_cnt = 0;
    run_period();
    run_period();
    check("rev_seg", int'(hue_seg), 5);
    check("rev_idx", int'(hue_idx), 3);
    check("rev_wrap", wrap_cnt, 1);
`else
    @(negedge clk);
    rst_n = 1'b1;
`endif

    for (int i = 0; i < 5000; i++) begin
      @(negedge clk);
      if ($urandom_range(149) == 0) enable = ~enable;
      if ($urandom_range(99) == 0)  freeze = ~freeze;
`ifdef HUE_CYCLER_REVERSE_EN
      if ($urandom_range(199) == 0) dir = ~dir;
`endif
      if ($urandom_range(999) == 0) begin
        #2 rst_n = 1'b0;
        #4 rst_n = 1'b1;
      end
    end

    repeat (2) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

`default_nettype wire
